// File: rtl/acc_core_param_if.sv
// Memory-side bundle for the accumulator core: one request/acknowledge
// transfer channel with separate read and write data paths.
interface acc_core_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/acc_core_param.sv
// Single-accumulator processor core with a multi-cycle FETCH/DECODE/EXEC
// control FSM and a req/ack memory port that tolerates wait states.
module acc_core_param #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  acc_core_param_if.master    mem,
  output logic                halted,
  output logic [OPW-1:0]      op_code,
  output logic [DW-OPW-1:0]   pc_out,
  output logic [DW-1:0]       ac_out,
  output logic                zero,
  output logic                carry
);
  localparam int unsigned AW = DW - OPW;

  localparam logic [OPW-1:0] OpLda = OPW'(0);
  localparam logic [OPW-1:0] OpSta = OPW'(1);
  localparam logic [OPW-1:0] OpAdd = OPW'(2);
  localparam logic [OPW-1:0] OpSub = OPW'(3);
  localparam logic [OPW-1:0] OpAnd = OPW'(4);
  localparam logic [OPW-1:0] OpJmp = OPW'(5);
  localparam logic [OPW-1:0] OpJz  = OPW'(6);
  localparam logic [OPW-1:0] OpHlt = OPW'(7);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StExec} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] ac_q;
  logic          carry_q;

  logic [OPW-1:0] op;
  logic [AW-1:0]  operand;
  logic           xfer_done;
  logic [DW:0]    sum;
  logic [DW:0]    diff;

  assign op        = ir_q[DW-1:AW];
  assign operand   = ir_q[AW-1:0];
  // mem.req is itself a pure function of state, so this adds no output path.
  assign xfer_done = mem.req & mem.ack;
  assign sum       = {1'b0, ac_q} + {1'b0, mem.rdata};
  // Top bit of the widened difference is the borrow, i.e. M[a] > AC.
  assign diff      = {1'b0, ac_q} - {1'b0, mem.rdata};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state decode; transfer states wait for the completing edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  if (xfer_done) state_d = StDecode;
      StDecode: begin
        if (op == OpJmp || op == OpJz) state_d = StFetch;
        else if (op == OpHlt)          state_d = StIdle;
        else                           state_d = StExec;
      end
      StExec:   if (xfer_done) state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  // Memory control outputs, decoded from registered state and IR only.
  always_comb begin
    mem.req  = 1'b0;
    mem.we   = 1'b0;
    mem.addr = '0;
    case (state_q)
      StFetch: begin
        mem.req  = 1'b1;
        mem.addr = pc_q;
      end
      StExec: begin
        mem.req  = 1'b1;
        mem.we   = (op == OpSta);
        mem.addr = operand;
      end
      default: ;
    endcase
  end

  // Datapath registers; updates land only on completing edges or in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (xfer_done) begin
            ir_q <= mem.rdata;
            pc_q <= pc_q + AW'(1);
          end
        end
        StDecode: begin
          if (op == OpJmp || (op == OpJz && zero)) pc_q <= operand;
        end
        StExec: begin
          if (xfer_done) begin
            case (op)
              OpLda: ac_q <= mem.rdata;
              OpAdd: {carry_q, ac_q} <= sum;
              OpSub: {carry_q, ac_q} <= diff;
              OpAnd: ac_q <= ac_q & mem.rdata;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.wdata = ac_q;
  assign halted    = (state_q == StIdle);
  assign op_code   = op;
  assign pc_out    = pc_q;
  assign ac_out    = ac_q;
  assign zero      = (ac_q == '0);
  assign carry     = carry_q;
endmodule

// File: doc/acc_core_param.md
# acc_core_param

Parametrised successor to the accumulator datapath: a complete single-accumulator processor core with its own multi-cycle control FSM. It has separate read and write data ports in place of the shared tristate bus, a req/ack memory handshake that tolerates wait states, and an extended instruction set with SUB, AND, conditional jump and halt. It sits between the top-level start control and a single unified (von Neumann) instruction and data memory.

## Interface
Parameters:
- DW, 8, data and instruction width
- OPW, 3, opcode field width; AW = DW-OPW is a derived localparam (default 5, 32 words)

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  leave IDLE and begin fetching from the current PC; honoured only in IDLE
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  AW  transfer address
- mem_wdata  out  DW  write data (always the AC value)
- mem_rdata  in  DW  read data, sampled on the completing edge
- mem_ack  in  1  transfer completes on a rising edge where mem_req & mem_ack are both high
- halted  out  1  core is in IDLE
- op_code  out  OPW  IR[DW-1:DW-AW... top OPW bits], i.e. IR[DW-1:AW]
- pc_out  out  AW  program counter
- ac_out  out  DW  accumulator
- zero  out  1  combinational (AC == 0)
- carry  out  1  carry/borrow flag

## Operation
- Instruction format: IR[DW-1:AW] = opcode, IR[AW-1:0] = operand address a.
- Opcodes:
  - 0 LDA: AC ← M[a]
  - 1 STA: M[a] ← AC
  - 2 ADD: {carry,AC} ← AC+M[a], computed (DW+1) bits wide
  - 3 SUB: AC ← AC−M[a] mod 2^DW; carry ← (M[a] > AC)
  - 4 AND: AC ← AC & M[a]
  - 5 JMP: PC ← a
  - 6 JZ: PC ← a if zero, otherwise no change
  - 7 HLT
- carry changes only on ADD and SUB.
- PC increments mod 2^AW; 2^AW−1 wraps to 0.
- FSM states, registered: IDLE, FETCH, DECODE, EXEC.
  - IDLE: mem_req = 0. If start is high, go to FETCH.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. On completion: IR ← rdata, PC ← PC+1, go to DECODE.
  - DECODE: no request.
    - JMP/JZ: update PC as above, go to FETCH.
    - HLT: go to IDLE. PC stays pointing past the HLT, so a later start resumes execution there.
    - Any other opcode: go to EXEC.
  - EXEC: mem_req = 1, mem_addr = a, mem_we = (opcode == STA). On completion: apply the AC/carry update, go to FETCH.
- mem_addr, mem_we and mem_wdata are held stable while mem_req is high and the transfer has not yet completed.
- mem_ack while mem_req is low is ignored.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, halted = 1, PC = 0, IR = 0 (op_code = 0), AC = 0, carry = 0, zero = 1, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- rst overrides everything, including mid-transfer. mem_req is 0 from the cycle after the reset edge, and any ack in flight is discarded with no register update.
- Control outputs are decoded from the registered state and IR only; there is no combinational path from mem_ack or mem_rdata to any output.
- With zero wait states (ack returned in the same cycle as req), in edges from FETCH entry:
  - LDA/STA/ADD/SUB/AND: 3 (FETCH, DECODE, EXEC)
  - JMP/JZ: 2
  - HLT: 2, then halted = 1
- Each cycle of ack delay adds one edge to the state that is waiting.
- Back-to-back transfers (EXEC→FETCH) may keep mem_req high continuously; each req&ack edge counts as exactly one transfer.
- start in IDLE → mem_req = 1 in the following cycle.

## Test plan
- Reset, then hold start low for 10 cycles → all outputs at their reset values; mem_req never asserts.
- Program M[0]=0x0A, M[1]=0x4B, M[2]=0x2C, M[3]=0xE0, M[10]=0x7F, M[11]=0x81, zero-wait memory; pulse start → write of 0x00 to address 12; carry = 1, zero = 1, pc_out = 4, halted = 1 exactly 11 edges after FETCH entry.
- AC = 3, SUB of M = 5 → ac_out = 0xFE, carry = 1. Then JZ is not taken (PC advances by 1). After LDA of 0, JZ 7 → pc_out = 7.
- Hold ack low for 3 cycles during both the FETCH and the EXEC of an STA → mem_addr, mem_we and mem_wdata are stable throughout; exactly one write occurs; latency is 3+3+3 = 9 edges.
- JMP 31 with M[31] = LDA → after that fetch, pc_out = 0 (wrap-around).
- Assert rst during an EXEC wait state, with ack arriving in the same cycle → AC unchanged at 0, mem_req = 0 the next cycle, halted = 1; a following start refetches from address 0.
